// File: rtl/sap1_control_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sap1_control_sequencer : SAP-1 T-state counter, halt latch, microcode decode
// Option: SAP1_EARLY_END_EN ends an instruction at its last non-empty step.
// Rev 1.0
// ---------------------------------------------------------------------------
module sap1_control_sequencer #(
  parameter int NUM_STEPS = 5,
  parameter int STEP_W    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [3:0]        opcode,
  input  logic              carry_flag,
  input  logic              zero_flag,
  output logic [15:0]       ctrl,
  output logic [STEP_W-1:0] step,
  output logic              halted
);

  localparam logic [15:0] C_HLT = 16'h8000;
  localparam logic [15:0] C_MI  = 16'h4000;
  localparam logic [15:0] C_RI  = 16'h2000;
  localparam logic [15:0] C_RO  = 16'h1000;
  localparam logic [15:0] C_IO  = 16'h0800;
  localparam logic [15:0] C_II  = 16'h0400;
  localparam logic [15:0] C_AI  = 16'h0200;
  localparam logic [15:0] C_AO  = 16'h0100;
  localparam logic [15:0] C_EO  = 16'h0080;
  localparam logic [15:0] C_SU  = 16'h0040;
  localparam logic [15:0] C_BI  = 16'h0020;
  localparam logic [15:0] C_OI  = 16'h0010;
  localparam logic [15:0] C_CE  = 16'h0008;
  localparam logic [15:0] C_CO  = 16'h0004;
  localparam logic [15:0] C_J   = 16'h0002;
  localparam logic [15:0] C_FI  = 16'h0001;

  localparam logic [STEP_W-1:0] T0        = STEP_W'(0);
  localparam logic [STEP_W-1:0] T1        = STEP_W'(1);
  localparam logic [STEP_W-1:0] T2        = STEP_W'(2);
  localparam logic [STEP_W-1:0] T3        = STEP_W'(3);
  localparam logic [STEP_W-1:0] T4        = STEP_W'(4);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);
  localparam logic [3:0]        OP_HLT    = 4'hF;

  logic [STEP_W-1:0] step_q, step_d;
  logic              halted_q, halted_d;

  function automatic logic [15:0] decode(input logic [STEP_W-1:0] s,
                                         input logic [3:0] op,
                                         input logic c, input logic z);
    logic [15:0] w;
    w = 16'h0000;
    if (s == T0) begin
      w = C_CO | C_MI;
    end else if (s == T1) begin
      w = C_RO | C_II | C_CE;
    end else begin
      case (op)
        4'h1: w = (s == T2) ? (C_IO | C_MI) : (s == T3) ? (C_RO | C_AI) : 16'h0000;
        4'h2, 4'h3: begin
          if (s == T2)      w = C_IO | C_MI;
          else if (s == T3) w = C_RO | C_BI;
          else if (s == T4) w = C_EO | C_AI | C_FI | ((op == 4'h3) ? C_SU : 16'h0000);
        end
        4'h4: w = (s == T2) ? (C_IO | C_MI) : (s == T3) ? (C_AO | C_RI) : 16'h0000;
        4'h5: w = (s == T2) ? (C_IO | C_AI) : 16'h0000;
        4'h6: w = (s == T2) ? (C_IO | C_J) : 16'h0000;
        4'h7: w = (s == T2 && c) ? (C_IO | C_J) : 16'h0000;
        4'h8: w = (s == T2 && z) ? (C_IO | C_J) : 16'h0000;
        4'hE: w = (s == T2) ? (C_AO | C_OI) : 16'h0000;
        4'hF: w = (s == T2) ? C_HLT : 16'h0000;
        default: w = 16'h0000;
      endcase
    end
    return w;
  endfunction

  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (run && !halted_q) begin
      // HLT freezes the counter at T2 rather than advancing past it
      if (step_q == T2 && opcode == OP_HLT) begin
        halted_d = 1'b1;
      end else if (step_q == LAST_STEP) begin
        step_d = T0;
`ifdef SAP1_EARLY_END_EN
      end else if (step_q >= T2 &&
                   decode(step_q + STEP_W'(1), opcode, carry_flag, zero_flag) == 16'h0000) begin
        step_d = T0;
`endif
      end else begin
        step_d = step_q + STEP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    ctrl = 16'h0000;
    if (reset)         ctrl = 16'h0000;
    else if (halted_q) ctrl = C_HLT;
    else if (run)      ctrl = decode(step_q, opcode, carry_flag, zero_flag);
  end

  assign step   = step_q;
  assign halted = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_sap1_control_sequencer.sv
`default_nettype none
// Bench for sap1_control_sequencer: directed scenarios then random stimulus
// compared against an instruction-level model of the SAP-1 microprogram.
module tb_sap1_control_sequencer;
  localparam int NS = 5;

  logic        clk = 1'b0;
  logic        reset, run, carry_flag, zero_flag;
  logic [3:0]  opcode;
  logic [15:0] ctrl;
  logic [2:0]  step;
  logic        halted;

  int n_assert = 0;
  int n_fail   = 0;
  int m_step   = 0;
  bit m_halted = 1'b0;

  always #5 clk = ~clk;

  sap1_control_sequencer #(.NUM_STEPS(NS), .STEP_W(3)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode),
    .carry_flag(carry_flag), .zero_flag(zero_flag),
    .ctrl(ctrl), .step(step), .halted(halted)
  );

  // Execute-phase words of each instruction, in order from T2; n = count.
  function automatic void exec_list(input logic [3:0] op, input logic c, input logic z,
                                    output logic [15:0] w0, output logic [15:0] w1,
                                    output logic [15:0] w2, output int n);
    w0 = 16'h0; w1 = 16'h0; w2 = 16'h0; n = 0;
    case (op)
      4'h1: begin w0 = 16'h4800; w1 = 16'h1200; n = 2; end
      4'h2: begin w0 = 16'h4800; w1 = 16'h1020; w2 = 16'h0281; n = 3; end
      4'h3: begin w0 = 16'h4800; w1 = 16'h1020; w2 = 16'h02C1; n = 3; end
      4'h4: begin w0 = 16'h4800; w1 = 16'h2100; n = 2; end
      4'h5: begin w0 = 16'h0A00; n = 1; end
      4'h6: begin w0 = 16'h0802; n = 1; end
      4'h7: if (c) begin w0 = 16'h0802; n = 1; end
      4'h8: if (z) begin w0 = 16'h0802; n = 1; end
      4'hE: begin w0 = 16'h0110; n = 1; end
      4'hF: begin w0 = 16'h8000; n = 1; end
      default: n = 0;
    endcase
  endfunction

  function automatic logic [15:0] model_ctrl();
    logic [15:0] w0, w1, w2;
    int n;
    exec_list(opcode, carry_flag, zero_flag, w0, w1, w2, n);
    if (reset)       return 16'h0000;
    if (m_halted)    return 16'h8000;
    if (!run)        return 16'h0000;
    if (m_step == 0) return 16'h4004;
    if (m_step == 1) return 16'h1408;
    if (m_step - 2 >= n) return 16'h0000;
    case (m_step - 2)
      0:       return w0;
      1:       return w1;
      default: return w2;
    endcase
  endfunction

  task automatic check(input string tag);
    logic [15:0] e;
    logic [2:0]  es;
    #1;
    e  = model_ctrl();
    es = m_step[2:0];
    n_assert++;
    assert (ctrl === e) else begin
      n_fail++;
      $error("FAIL %s ctrl got %h expected %h", tag, ctrl, e);
    end
    n_assert++;
    assert (step === es) else begin
      n_fail++;
      $error("FAIL %s step got %0d expected %0d", tag, step, es);
    end
    n_assert++;
    assert (halted === m_halted) else begin
      n_fail++;
      $error("FAIL %s halted got %0b expected %0b", tag, halted, m_halted);
    end
  endtask

  task automatic step_clk();
    int ns;
    bit nh;
    logic [15:0] w0, w1, w2;
    int n;
    exec_list(opcode, carry_flag, zero_flag, w0, w1, w2, n);
    ns = m_step;
    nh = m_halted;
    if (reset) begin
      ns = 0; nh = 1'b0;
    end else if (!m_halted && run) begin
      if (m_step == 2 && opcode == 4'hF) nh = 1'b1;
      else if (m_step == NS - 1) ns = 0;
`ifdef SAP1_EARLY_END_EN
      else if (m_step >= 2 && m_step - 1 >= n) ns = 0;
`endif
      else ns = m_step + 1;
    end
    @(posedge clk);
    m_step   = ns;
    m_halted = nh;
    #1;
  endtask

  task automatic cyc(input string tag);
    check(tag);
    step_clk();
  endtask

  task automatic run_to_step(input int s, input string tag);
    for (int i = 0; i < 12 && m_step != s; i++) cyc(tag);
    n_assert++;
    assert (m_step == s && step === 3'(s)) else begin
      n_fail++;
      $error("FAIL %s_reach step got %0d expected %0d", tag, step, s);
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b1; opcode = 4'h2; carry_flag = 1'b0; zero_flag = 1'b0;
    step_clk();
    for (int i = 0; i < 3; i++) cyc("reset_hold");
    reset = 1'b0;
    for (int i = 0; i < 6; i++) cyc("add_seq");
    opcode = 4'h3;
    for (int i = 0; i < 6; i++) cyc("sub_seq");
    opcode = 4'h7; carry_flag = 1'b1;
    run_to_step(2, "jc_taken");
    cyc("jc_taken");
    carry_flag = 1'b0;
    run_to_step(2, "jc_untaken");
    cyc("jc_untaken");
    opcode = 4'h8; zero_flag = 1'b1;
    run_to_step(2, "jz_taken");
    cyc("jz_taken");
    opcode = 4'h0;
    run_to_step(0, "nop");
    for (int i = 0; i < 6; i++) cyc("nop_seq");
    opcode = 4'hF;
    run_to_step(2, "hlt");
    for (int i = 0; i < 22; i++) begin
      run = (i % 3 != 0);
      cyc("halted_hold");
    end
    run = 1'b1; reset = 1'b1;
    cyc("halt_reset");
    reset = 1'b0; opcode = 4'h1;
    run_to_step(3, "lda");
    run = 1'b0;
    for (int i = 0; i < 4; i++) cyc("lda_pause");
    run = 1'b1;
    for (int i = 0; i < 3; i++) cyc("lda_resume");
    opcode = 4'h2;
    run_to_step(3, "add_abort");
    reset = 1'b1;
    cyc("add_abort_rst");
    check("add_abort_rst_hi");
    reset = 1'b0;
    for (int i = 0; i < 2; i++) cyc("add_abort_rel");

    for (int i = 0; i < 500; i++) begin
      reset      = ($urandom_range(0, 39) == 0);
      run        = ($urandom_range(0, 7) != 0);
      opcode     = 4'($urandom_range(0, 15));
      carry_flag = 1'($urandom_range(0, 1));
      zero_flag  = 1'($urandom_range(0, 1));
      cyc("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
